serial_adder: RTL
=================

Name: serial_adder

Overview:
Bit-serial adder built around the team's existing full_adder cell. It adds two WIDTH-bit operands one bit per clock, LSB first, with a registered carry fed back into the cell. It sits directly downstream of full_adder and consumes its sum and carry every cycle. A start/ready/done handshake lets a controller or bench issue additions back to back.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk    input   1      clock, all state updates on rising edge
rst    input   1      synchronous active-high reset
start  input   1      request; accepted only when ready=1
a      input   WIDTH  operand A, sampled on accepted start
b      input   WIDTH  operand B, sampled on accepted start
cin    input   1      carry-in, sampled on accepted start
ready  output  1      block can accept start this cycle
busy   output  1      addition in progress
done   output  1      single-cycle pulse: sum/cout valid and newly updated
sum    output  WIDTH  result, held stable between completions
cout   output  1      final carry-out, held with sum

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; ready=1, busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and bit counter are cleared.
  - rst dominates start.
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1. On start=1:
  - Load opA<=a, opB<=b, carry<=cin, acc<=0, cnt<=0.
  - Go to SHIFT.
- SHIFT: busy=1, ready=0. Each cycle:
  - full_adder is fed opA[0], opB[0], carry.
  - acc <= {fa_sum, acc[WIDTH-1:1]} (result shifts in at the MSB, ends LSB-aligned).
  - opA and opB shift right by 1; carry <= fa_carry; cnt++.
  - When cnt==WIDTH-1: sum <= final acc value (including this cycle's bit), cout <= fa_carry. Go to DONE.
- DONE: done=1 for exactly one cycle; ready=1, busy=0.
  - start=1 in DONE: accepted exactly as in IDLE (loads operands, goes to SHIFT).
  - Otherwise go to IDLE.
- Latency: start accepted at edge N; done=1 during the cycle after edge N+WIDTH. Throughput is one addition per WIDTH+1 cycles with back-to-back starts.
- sum/cout change only on the completion edge and hold until the next completion or reset. Intermediate bits are never visible on sum.
- start while busy: ignored, no effect on the operation in flight, no queuing.
- a/b/cin changing while busy: no effect, because operands are captured at acceptance.
- Reset mid-SHIFT: aborts the operation. done is not asserted, sum/cout are cleared to 0, the block returns to IDLE.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- cnt width is clog2(WIDTH). Terminal compare is against WIDTH-1, so there is no wrap hazard.

Decomposition:
- Package serial_adder_pkg: state enum typedef (IDLE, SHIFT, DONE) and the cnt width derivation as a function of WIDTH.
- One sub-module: the existing full_adder, instanced once as the bit-slice datapath.
- Control FSM, shift registers and carry flop live in serial_adder.

Test Plan:
- WIDTH=8; a=0x0F, b=0x01, cin=0, start pulse at cycle 0 -> done=1 at cycle 9 only; sum=0x10, cout=0; busy high during cycles 1-8.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start a=0x12, b=0x34, cin=0; at cycle 3 drive start=1 with a=0xAA, b=0x55 -> second start ignored; sum=0x46, cout=0; only one done pulse.
- Start a=0x80, b=0x80; assert rst at cycle 4 -> done never pulses; sum=0, cout=0, ready=1 from the cycle after reset.
- Back-to-back: start (0x01,0x02,0) at cycle 0, start (0x10,0x20,1) held during the done cycle 9 -> first done shows 0x03; second done at cycle 18 shows 0x31, cout=0.
- Random: 200 accepted starts with random a/b/cin and random start gaps -> every done matches a+b+cin; sum stable between done pulses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and helpers for the bit-serial adder.
//               - state_t   : control FSM state encoding (IDLE, SHIFT, DONE)
//               - cnt_width : bit-counter width derived from operand WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    // Clamp to 1 so a degenerate width never yields a zero-width vector.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit combinational full adder (bit-slice datapath).
// Ports       : a, b, cin  - addend bits and carry-in
//               sum, cout  - sum bit and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_prop;

    assign w_prop = a ^ b;
    assign sum    = w_prop ^ cin;
    assign cout   = (a & b) | (cin & w_prop);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder. Adds two WIDTH-bit operands LSB first, one
//               bit per clock, through a single full_adder slice with a
//               registered carry. start/ready/done handshake; back-to-back
//               starts are accepted in the DONE cycle.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               start, a, b, cin - request and operands (sampled on accept)
//               ready, busy      - can accept start / addition in progress
//               done             - one-cycle completion pulse
//               sum, cout        - result, held between completions
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_load;
    logic             w_shift;
    logic             w_last;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_acc_next;

    full_adder u_full_adder (
        .a    (r_op_a[0]),
        .b    (r_op_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // New bit enters at the MSB so after WIDTH shifts the result is LSB-aligned.
    assign w_acc_next = {w_fa_sum, r_acc[WIDTH-1:1]};

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                // A start here is taken exactly as from IDLE.
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand shifters, accumulator, carry, counter, result
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_carry <= cin;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_op_a  <= {1'b0, r_op_a[WIDTH-1:1]};
            r_op_b  <= {1'b0, r_op_b[WIDTH-1:1]};
            r_acc   <= w_acc_next;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CW'(1);
            // Publish only the finished word so partial bits never show.
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
